// File: rtl/battleship_shot_ctrl_if.sv
// battleship_shot_ctrl_if: board inputs, scorer handshake and status outputs of the shot controller
interface battleship_shot_ctrl_if;
  logic       Fire;
  logic [3:0] X;
  logic [3:0] Y;
  logic       BigReq;
  logic       Hit;
  logic       nearMiss;
  logic       Miss;
  logic       SomethingIsWrong;
  logic [3:0] NumHitsIn;
  logic [4:0] BiggestIn;
  logic [3:0] ShotX;
  logic [3:0] ShotY;
  logic       Big;
  logic [1:0] BigLeft;
  logic       ScoreThis;
  logic       Busy;
  logic [6:0] ShotsTaken;
  logic [4:0] HitTotal;
  logic [1:0] LastResult;
  logic [4:0] LastBiggest;
  logic       Repeat;
  logic       Error;
  logic       GameOver;
  // controller side: initiates shots towards the scorer
  modport master (
    input  Fire, X, Y, BigReq, Hit, nearMiss, Miss, SomethingIsWrong, NumHitsIn, BiggestIn,
    output ShotX, ShotY, Big, BigLeft, ScoreThis, Busy, ShotsTaken, HitTotal, LastResult,
           LastBiggest, Repeat, Error, GameOver
  );
  // environment side: board inputs, scorer responses, display consumers
  modport slave (
    output Fire, X, Y, BigReq, Hit, nearMiss, Miss, SomethingIsWrong, NumHitsIn, BiggestIn,
    input  ShotX, ShotY, Big, BigLeft, ScoreThis, Busy, ShotsTaken, HitTotal, LastResult,
           LastBiggest, Repeat, Error, GameOver
  );
endinterface

// File: rtl/battleship_shot_ctrl.sv
// battleship_shot_ctrl: issues one scored shot at a time and accumulates game state from the scorer
module battleship_shot_ctrl #(
  parameter int RESP_LAT    = 0,
  parameter int TOTAL_CELLS = 19,
  parameter int MAX_SHOTS   = 50,
  parameter int BIG_INIT    = 2
) (
  input logic clock,
  input logic reset_L,
  battleship_shot_ctrl_if.master bus
);
  localparam int CW = (RESP_LAT > 0) ? $clog2(RESP_LAT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OVER} state_t;
  state_t      r_state, w_next, w_after;
  logic [3:0]  r_shot_x, r_shot_y;
  logic        r_big;
  logic [1:0]  r_big_left;
  logic [6:0]  r_shots;
  logic [4:0]  r_hits;
  logic [1:0]  r_last_res;
  logic [4:0]  r_last_big;
  logic        r_repeat, r_error;
  logic [99:0] r_map;
  logic [CW-1:0] r_cnt;
  logic        w_in_range, w_shot_in_range, w_repeat, w_launch, w_sample, w_accept, w_done;
  logic [6:0]  w_idx_in, w_idx_shot, w_shots_new;
  logic [5:0]  w_hit_sum;
  logic [4:0]  w_hits_new;
  assign bus.ShotX       = r_shot_x;
  assign bus.ShotY       = r_shot_y;
  assign bus.Big         = r_big;
  assign bus.BigLeft     = r_big_left;
  assign bus.ScoreThis   = (r_state == ISSUE);
  assign bus.Busy        = (r_state == ISSUE) || (r_state == WAIT);
  assign bus.GameOver    = (r_state == OVER);
  assign bus.ShotsTaken  = r_shots;
  assign bus.HitTotal    = r_hits;
  assign bus.LastResult  = r_last_res;
  assign bus.LastBiggest = r_last_big;
  assign bus.Repeat      = r_repeat;
  assign bus.Error       = r_error;
  // repeat detection, response sampling point and the accumulated values an accepted shot would produce
  always_comb begin
    w_in_range      = (bus.X >= 4'd1) && (bus.X <= 4'd10) && (bus.Y >= 4'd1) && (bus.Y <= 4'd10);
    w_shot_in_range = (r_shot_x >= 4'd1) && (r_shot_x <= 4'd10) && (r_shot_y >= 4'd1) && (r_shot_y <= 4'd10);
    w_idx_in        = 7'(bus.Y - 4'd1) * 7'd10 + 7'(bus.X - 4'd1);
    w_idx_shot      = 7'(r_shot_y - 4'd1) * 7'd10 + 7'(r_shot_x - 4'd1);
    w_repeat        = (r_state == IDLE) && bus.Fire && !bus.BigReq && w_in_range && r_map[w_idx_in];
    w_launch        = (r_state == IDLE) && bus.Fire && !w_repeat;
    w_sample        = (RESP_LAT == 0) ? (r_state == ISSUE) : ((r_state == WAIT) && (r_cnt == CW'(1)));
    w_accept        = w_sample && !bus.SomethingIsWrong;
    w_hit_sum       = {1'b0, r_hits} + {2'b00, bus.NumHitsIn};
    w_hits_new      = w_hit_sum[5] ? 5'd31 : w_hit_sum[4:0];
    w_shots_new     = r_shots + 7'd1;
    w_done          = (w_hits_new >= 5'(TOTAL_CELLS)) || (w_shots_new == 7'(MAX_SHOTS));
    w_after         = (!bus.SomethingIsWrong && w_done) ? OVER : IDLE;
  end
  // next-state selection; OVER is only left through reset
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = w_launch ? ISSUE : IDLE;
      ISSUE: w_next = (RESP_LAT > 0) ? WAIT : w_after;
      WAIT:  w_next = w_sample ? w_after : WAIT;
      OVER:  w_next = OVER;
    endcase
  end
  // state register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // shot latch, wait counter, pulses and game accumulators
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_shot_x   <= '0;
      r_shot_y   <= '0;
      r_big      <= 1'b0;
      r_big_left <= 2'(BIG_INIT);
      r_shots    <= '0;
      r_hits     <= '0;
      r_last_res <= '0;
      r_last_big <= '0;
      r_repeat   <= 1'b0;
      r_error    <= 1'b0;
      r_map      <= '0;
      r_cnt      <= '0;
    end else begin
      r_repeat <= w_repeat;
      r_error  <= w_sample && bus.SomethingIsWrong;
      if (w_launch) begin
        r_shot_x <= bus.X;
        r_shot_y <= bus.Y;
        r_big    <= bus.BigReq;
      end
      if (r_state == ISSUE) r_cnt <= CW'(RESP_LAT);
      else if (r_state == WAIT) r_cnt <= r_cnt - CW'(1);
      if (w_accept) begin
        r_shots    <= w_shots_new;
        r_hits     <= w_hits_new;
        r_last_res <= bus.Hit ? 2'b11 : bus.nearMiss ? 2'b10 : bus.Miss ? 2'b01 : 2'b00;
        r_last_big <= bus.BiggestIn;
        if (w_shot_in_range) r_map[w_idx_shot] <= 1'b1;
        if (r_big) r_big_left <= r_big_left - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_battleship_shot_ctrl.sv
// tb_battleship_shot_ctrl: random and directed shots against a game-rule model, two response latencies
module tb_battleship_shot_ctrl;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst3 = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  battleship_shot_ctrl_if b0();
  battleship_shot_ctrl_if b3();
  battleship_shot_ctrl #(.RESP_LAT(0)) d0 (.clock(clk), .reset_L(rst0), .bus(b0));
  battleship_shot_ctrl #(.RESP_LAT(3)) d3 (.clock(clk), .reset_L(rst3), .bus(b3));

  int m_shots, m_hits, m_big, m_res;
  logic [4:0] m_bgst;
  bit m_over;
  bit m_hist[100];

  task automatic model_reset();
    m_shots = 0; m_hits = 0; m_big = 2; m_res = 0; m_bgst = '0; m_over = 0;
    foreach (m_hist[i]) m_hist[i] = 0;
  endtask

  task automatic reset0();
    @(negedge clk);
    {b0.Fire, b0.X, b0.Y, b0.BigReq, b0.Hit, b0.nearMiss, b0.Miss, b0.SomethingIsWrong, b0.NumHitsIn, b0.BiggestIn} = '0;
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    model_reset();
  endtask

  task automatic shot0(input int x, input int y, input bit big, input bit hit, input bit near,
                       input bit miss, input bit wrong, input int n, input logic [4:0] bg);
    bit in_rng, exp_rep, exp_iss;
    in_rng  = (x >= 1 && x <= 10 && y >= 1 && y <= 10);
    exp_rep = !m_over && !big && in_rng && m_hist[in_rng ? (y - 1) * 10 + x - 1 : 0];
    exp_iss = !m_over && !exp_rep;
    b0.X = 4'(x); b0.Y = 4'(y); b0.BigReq = big;
    b0.Hit = hit; b0.nearMiss = near; b0.Miss = miss; b0.SomethingIsWrong = wrong;
    b0.NumHitsIn = 4'(n); b0.BiggestIn = bg; b0.Fire = 1'b1;
    @(negedge clk);
    b0.Fire = 1'b0;
    total++;
    if (b0.ScoreThis !== exp_iss) begin bad++; $display("FAIL strobe (%0d,%0d) got=%b exp=%b", x, y, b0.ScoreThis, exp_iss); end
    total++;
    if ({b0.Repeat, b0.Error} !== {exp_rep, 1'b0}) begin bad++; $display("FAIL repeat (%0d,%0d) got rep/err=%b%b exp=%b0", x, y, b0.Repeat, b0.Error, exp_rep); end
    if (exp_iss) begin
      total++;
      if ({b0.ShotX, b0.ShotY, b0.Big, b0.Busy} !== {4'(x), 4'(y), big, 1'b1})
        begin bad++; $display("FAIL issue_target got=%h/%h big=%b busy=%b exp=%0d/%0d big=%b busy=1", b0.ShotX, b0.ShotY, b0.Big, b0.Busy, x, y, big); end
    end
    @(negedge clk);
    if (exp_iss && !wrong) begin
      m_shots++;
      m_hits = (m_hits + n > 31) ? 31 : m_hits + n;
      if (in_rng) m_hist[(y - 1) * 10 + x - 1] = 1;
      if (big) m_big--;
      m_res = hit ? 3 : near ? 2 : miss ? 1 : 0;
      m_bgst = bg;
      if (m_hits >= 19 || m_shots == 50) m_over = 1;
    end
    total++;
    if (b0.Error !== (exp_iss && wrong)) begin bad++; $display("FAIL error_pulse (%0d,%0d) got=%b exp=%b", x, y, b0.Error, exp_iss && wrong); end
    total++;
    if ({b0.Repeat, b0.ScoreThis, b0.Busy, b0.GameOver} !== {3'b000, m_over})
      begin bad++; $display("FAIL flags_after got rep/st/busy/go=%b%b%b%b exp=000%b", b0.Repeat, b0.ScoreThis, b0.Busy, b0.GameOver, m_over); end
    total++;
    if ({b0.ShotsTaken, b0.HitTotal, b0.BigLeft, b0.LastResult, b0.LastBiggest} !== {7'(m_shots), 5'(m_hits), 2'(m_big), 2'(m_res), m_bgst})
      begin bad++; $display("FAIL counters got shots=%0d hits=%0d big=%0d res=%0d bg=%b exp shots=%0d hits=%0d big=%0d res=%0d bg=%b",
        b0.ShotsTaken, b0.HitTotal, b0.BigLeft, b0.LastResult, b0.LastBiggest, m_shots, m_hits, m_big, m_res, m_bgst); end
  endtask

  task automatic test_reset();
    reset0();
    shot0(2, 2, 0, 1, 0, 0, 0, 3, 5'b00010);
    #1 rst0 = 1'b0;
    #1;
    total++;
    if ({b0.ShotsTaken, b0.HitTotal, b0.LastResult, b0.LastBiggest} !== '0)
      begin bad++; $display("FAIL reset_counters got shots=%0d hits=%0d res=%0d bg=%b exp all 0", b0.ShotsTaken, b0.HitTotal, b0.LastResult, b0.LastBiggest); end
    total++;
    if (b0.BigLeft !== 2'd2) begin bad++; $display("FAIL reset_bigleft got=%0d exp=2", b0.BigLeft); end
    total++;
    if ({b0.ShotX, b0.ShotY, b0.Big, b0.ScoreThis, b0.Busy, b0.Repeat, b0.Error, b0.GameOver} !== '0)
      begin bad++; $display("FAIL reset_outputs got=%h exp=0", {b0.ShotX, b0.ShotY, b0.Big, b0.ScoreThis, b0.Busy, b0.Repeat, b0.Error, b0.GameOver}); end
    @(negedge clk);
    rst0 = 1'b1;
    model_reset();
    shot0(2, 2, 0, 1, 0, 0, 0, 1, 5'b00001);
  endtask

  task automatic test_single_and_repeat();
    reset0();
    shot0(3, 3, 0, 1, 0, 0, 0, 1, 5'b10000);
    shot0(3, 3, 0, 1, 0, 0, 0, 1, 5'b10000);
    shot0(4, 3, 0, 0, 1, 1, 0, 0, 5'b00000);
    shot0(5, 3, 0, 0, 0, 1, 0, 0, 5'b00000);
  endtask

  task automatic test_big();
    shot0(8, 6, 1, 1, 0, 0, 0, 2, 5'b01000);
    shot0(3, 3, 1, 1, 1, 1, 0, 1, 5'b10000);
    shot0(1, 10, 1, 0, 1, 0, 0, 0, 5'b00000);
    shot0(8, 6, 0, 1, 0, 0, 0, 2, 5'b01000);
  endtask

  task automatic test_error();
    shot0(0, 5, 0, 1, 0, 0, 1, 3, 5'b00100);
    shot0(11, 11, 1, 0, 0, 1, 1, 0, 5'b00000);
    shot0(10, 10, 0, 0, 0, 1, 0, 0, 5'b00000);
  endtask

  task automatic test_game_over_hits();
    reset0();
    shot0(1, 1, 0, 1, 0, 0, 0, 9, 5'b10000);
    shot0(2, 1, 0, 1, 0, 0, 0, 9, 5'b01000);
    shot0(3, 1, 0, 1, 0, 0, 0, 1, 5'b00001);
    shot0(4, 1, 0, 1, 0, 0, 0, 1, 5'b00001);
    shot0(1, 1, 0, 1, 0, 0, 0, 1, 5'b00001);
  endtask

  task automatic test_max_shots();
    reset0();
    for (int i = 0; i < 50; i++) shot0(i % 10 + 1, i / 10 + 1, 0, 0, 0, 1, 0, 0, 5'b00000);
    shot0(1, 6, 0, 1, 0, 0, 0, 1, 5'b00001);
  endtask

  task automatic test_random();
    int x, y, n;
    bit big, wrong, hit, near;
    reset0();
    for (int i = 0; i < 120; i++) begin
      if (m_over && $urandom_range(0, 1) == 1) reset0();
      x = $urandom_range(0, 11);
      y = $urandom_range(0, 11);
      big = (m_big > 0) && ($urandom_range(0, 3) == 0);
      wrong = ($urandom_range(0, 7) == 0) || !(x >= 1 && x <= 10 && y >= 1 && y <= 10);
      n = $urandom_range(0, 3);
      hit = (n > 0);
      near = !hit && ($urandom_range(0, 1) == 1);
      shot0(x, y, big, hit, near, !hit && !near, wrong, n, hit ? 5'(1 << $urandom_range(0, 4)) : 5'b00000);
    end
  endtask

  task automatic test_latency();
    int busy_cnt, st_cnt, err_cnt;
    busy_cnt = 0; st_cnt = 0; err_cnt = 0;
    @(negedge clk);
    {b3.Fire, b3.X, b3.Y, b3.BigReq, b3.Hit, b3.nearMiss, b3.Miss, b3.SomethingIsWrong, b3.NumHitsIn, b3.BiggestIn} = '0;
    rst3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    b3.X = 4'd4; b3.Y = 4'd7; b3.SomethingIsWrong = 1'b1; b3.Fire = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin b3.X = 4'd9; b3.Y = 4'd9; end
      if (b3.Busy === 1'b1) busy_cnt++;
      if (b3.ScoreThis === 1'b1) st_cnt++;
      if (b3.Error === 1'b1) err_cnt++;
      if (k == 4) begin
        total++;
        if (b3.ShotsTaken !== 7'd0) begin bad++; $display("FAIL lat_early_sample got=%0d exp=0", b3.ShotsTaken); end
        b3.Fire = 1'b0; b3.SomethingIsWrong = 1'b0; b3.Hit = 1'b1; b3.NumHitsIn = 4'd2; b3.BiggestIn = 5'b00100;
      end
      if (k == 5) begin
        total++;
        if ({b3.ShotsTaken, b3.HitTotal, b3.LastResult, b3.LastBiggest, b3.Busy} !== {7'd1, 5'd2, 2'b11, 5'b00100, 1'b0})
          begin bad++; $display("FAIL lat_result got shots=%0d hits=%0d res=%0d bg=%b busy=%b exp 1 2 3 00100 0", b3.ShotsTaken, b3.HitTotal, b3.LastResult, b3.LastBiggest, b3.Busy); end
      end
    end
    total++;
    if (busy_cnt != 4) begin bad++; $display("FAIL lat_busy_cycles got=%0d exp=4", busy_cnt); end
    total++;
    if (st_cnt != 1) begin bad++; $display("FAIL lat_strobe_cycles got=%0d exp=1", st_cnt); end
    total++;
    if (err_cnt != 0) begin bad++; $display("FAIL lat_error_cycles got=%0d exp=0", err_cnt); end
    total++;
    if ({b3.ShotX, b3.ShotY, b3.ShotsTaken} !== {4'd4, 4'd7, 7'd1}) begin bad++; $display("FAIL lat_ignored_fire got=%0d/%0d shots=%0d exp=4/7 shots=1", b3.ShotX, b3.ShotY, b3.ShotsTaken); end
  endtask

  task automatic test_reset_mid_wait();
    b3.X = 4'd5; b3.Y = 4'd5; b3.BigReq = 1'b1; b3.Fire = 1'b1;
    @(negedge clk);
    b3.Fire = 1'b0;
    @(negedge clk);
    #2 rst3 = 1'b0;
    #1;
    total++;
    if ({b3.Busy, b3.ScoreThis, b3.GameOver, b3.ShotsTaken, b3.HitTotal, b3.LastResult, b3.BigLeft} !== {3'b000, 7'd0, 5'd0, 2'd0, 2'd2})
      begin bad++; $display("FAIL reset_mid_wait got busy=%b shots=%0d hits=%0d res=%0d big=%0d exp busy=0 0 0 0 2", b3.Busy, b3.ShotsTaken, b3.HitTotal, b3.LastResult, b3.BigLeft); end
    @(negedge clk);
    rst3 = 1'b1;
    b3.X = 4'd4; b3.Y = 4'd7; b3.BigReq = 1'b0; b3.Fire = 1'b1;
    @(negedge clk);
    b3.Fire = 1'b0;
    total++;
    if ({b3.ScoreThis, b3.Repeat} !== 2'b10) begin bad++; $display("FAIL map_cleared got st/rep=%b%b exp=10", b3.ScoreThis, b3.Repeat); end
    repeat (4) @(negedge clk);
    total++;
    if ({b3.ShotsTaken, b3.HitTotal, b3.Busy} !== {7'd1, 5'd2, 1'b0}) begin bad++; $display("FAIL post_reset_shot got shots=%0d hits=%0d busy=%b exp 1 2 0", b3.ShotsTaken, b3.HitTotal, b3.Busy); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_and_repeat();
    test_big();
    test_error();
    test_game_over_hits();
    test_max_shots();
    test_random();
    test_latency();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
